// File: rtl/sirv_debug_entry_ctrl.sv
// ---------------------------------------------------------------------------
// sirv_debug_entry_ctrl
//
// Sequences the core into and out of debug mode.
//
// Entry sources (checked in RUN, highest priority first):
//   1. ebreak retiring with dcsr.ebreakm set        -> cause 1, dpc = cmt_pc
//   2. any retire while a single step is armed      -> cause 4, dpc = cmt_npc
//   3. halt request (external or dcsr.halt)         -> drain, then cause 3
//
// On entry the controller writes dpc/dcause through the commit-side CSR
// ports, redirects fetch to the debug ROM and parks in HALTED.  A retiring
// dret in HALTED clears dcause, redirects fetch to dpc and returns to RUN.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   dbg_*_r         debug CSR state and external halt request
//   dpc_r           current dpc (return address on exit)
//   cmt_*           commit stage retire information (qualified by cmt_valid)
//   pipe_idle       no instruction in flight
//   next_pc         PC of the next unissued instruction
//   flush_ack       IFU accepted the redirect
//   cmt_dpc*        dpc write port
//   cmt_dcause*     dcause write port
//   issue_stall     blocks instruction issue
//   flush_req/pc    fetch redirect request and target
//   core_halted     core is parked in the debug ROM
//   drain_timeout   sticky: a drain ran out of time before pipe_idle
//
// Handshake: flush_req/flush_pc form a valid/ready pair with flush_ack.
// Once flush_req is raised it and flush_pc stay stable until the cycle in
// which flush_ack is seen high; that cycle completes the transfer and
// flush_req drops on the following cycle.  flush_ack while flush_req is low
// has no effect.
// ---------------------------------------------------------------------------
module sirv_debug_entry_ctrl #(
  parameter int                   PC_SIZE      = 32,
  parameter logic [PC_SIZE-1:0]   DBG_ROM_ADDR = PC_SIZE'(32'h0000_0800),
  parameter int                   DRAIN_TO     = 64,
  parameter int                   CNT_W        = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dbg_irq_r,
  input  logic               dbg_halt_r,
  input  logic               dbg_step_r,
  input  logic               dbg_ebreakm_r,
  input  logic [PC_SIZE-1:0] dpc_r,
  input  logic               cmt_valid,
  input  logic [PC_SIZE-1:0] cmt_pc,
  input  logic [PC_SIZE-1:0] cmt_npc,
  input  logic               cmt_ebreak,
  input  logic               cmt_dret,
  input  logic               pipe_idle,
  input  logic [PC_SIZE-1:0] next_pc,
  input  logic               flush_ack,
  output logic [PC_SIZE-1:0] cmt_dpc,
  output logic               cmt_dpc_ena,
  output logic [2:0]         cmt_dcause,
  output logic               cmt_dcause_ena,
  output logic               issue_stall,
  output logic               flush_req,
  output logic [PC_SIZE-1:0] flush_pc,
  output logic               core_halted,
  output logic               drain_timeout
);

  // dcause encodings
  localparam logic [2:0] CAUSE_NONE    = 3'd0;
  localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
  localparam logic [2:0] CAUSE_HALTREQ = 3'd3;
  localparam logic [2:0] CAUSE_STEP    = 3'd4;

  // Last drain cycle: the drain lasts at most DRAIN_TO cycles.
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TO - 1);

  // dpc is always written half-word aligned.
  localparam logic [PC_SIZE-1:0] PC_ALIGN_MASK = ~PC_SIZE'(1);

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_DRAIN     = 3'd1,
    ST_ENTER     = 3'd2,
    ST_FLUSH_IN  = 3'd3,
    ST_HALTED    = 3'd4,
    ST_EXIT      = 3'd5,
    ST_FLUSH_OUT = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         cause_q, cause_d;
  logic [PC_SIZE-1:0] dpc_q, dpc_d;
  logic               step_armed, step_armed_d;
  // Set once the first RUN cycle after exit has passed; that cycle is the
  // single issue slot granted to a stepped instruction.
  logic               step_issued, step_issued_d;
  logic [CNT_W-1:0]   drain_cnt, drain_cnt_d;
  logic               drain_timeout_q, drain_timeout_d;

  logic               ebreak_hit;
  logic               halt_req;

  assign ebreak_hit = cmt_valid & cmt_ebreak & dbg_ebreakm_r;
  assign halt_req   = dbg_irq_r | dbg_halt_r;

  // -------------------------------------------------------------------------
  // State and capture registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_RUN;
      cause_q         <= CAUSE_NONE;
      dpc_q           <= '0;
      step_armed      <= 1'b0;
      step_issued     <= 1'b0;
      drain_cnt       <= '0;
      drain_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cause_q         <= cause_d;
      dpc_q           <= dpc_d;
      step_armed      <= step_armed_d;
      step_issued     <= step_issued_d;
      drain_cnt       <= drain_cnt_d;
      drain_timeout_q <= drain_timeout_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and output decode.  Outputs depend on registered state only,
  // except flush_pc in FLUSH_OUT which forwards dpc_r.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    cause_d         = cause_q;
    dpc_d           = dpc_q;
    step_armed_d    = step_armed;
    step_issued_d   = step_issued;
    drain_cnt_d     = drain_cnt;
    drain_timeout_d = drain_timeout_q;

    cmt_dpc         = '0;
    cmt_dpc_ena     = 1'b0;
    cmt_dcause      = CAUSE_NONE;
    cmt_dcause_ena  = 1'b0;
    issue_stall     = 1'b0;
    flush_req       = 1'b0;
    flush_pc        = '0;
    core_halted     = 1'b0;

    case (state_q)
      ST_RUN: begin
        // With a step armed, only the first RUN cycle may issue.
        issue_stall   = step_armed & step_issued;
        step_issued_d = 1'b1;
        if (ebreak_hit) begin
          state_d = ST_ENTER;
          cause_d = CAUSE_EBREAK;
          dpc_d   = cmt_pc;
        end else if (cmt_valid & step_armed & ~cmt_dret) begin
          state_d      = ST_ENTER;
          cause_d      = CAUSE_STEP;
          dpc_d        = cmt_npc;
          step_armed_d = 1'b0;
        end else if (halt_req) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end

      ST_DRAIN: begin
        issue_stall = 1'b1;
        drain_cnt_d = drain_cnt + 1'b1;
        // The request may drop while draining; entry still completes.
        if (ebreak_hit) begin
          state_d = ST_ENTER;
          cause_d = CAUSE_EBREAK;
          dpc_d   = cmt_pc;
        end else if (pipe_idle) begin
          state_d = ST_ENTER;
          cause_d = CAUSE_HALTREQ;
          dpc_d   = next_pc;
        end else if (drain_cnt == DRAIN_LAST) begin
          state_d         = ST_ENTER;
          cause_d         = CAUSE_HALTREQ;
          dpc_d           = next_pc;
          drain_timeout_d = 1'b1;
        end
      end

      ST_ENTER: begin
        cmt_dpc        = dpc_q & PC_ALIGN_MASK;
        cmt_dpc_ena    = 1'b1;
        cmt_dcause     = cause_q;
        cmt_dcause_ena = 1'b1;
        issue_stall    = 1'b1;
        state_d        = ST_FLUSH_IN;
      end

      ST_FLUSH_IN: begin
        flush_req   = 1'b1;
        flush_pc    = DBG_ROM_ADDR;
        issue_stall = 1'b1;
        if (flush_ack) begin
          state_d = ST_HALTED;
        end
      end

      ST_HALTED: begin
        // ROM code runs freely; only dret leaves this state.
        core_halted = 1'b1;
        if (cmt_valid & cmt_dret) begin
          state_d = ST_EXIT;
        end
      end

      ST_EXIT: begin
        cmt_dcause     = CAUSE_NONE;
        cmt_dcause_ena = 1'b1;
        issue_stall    = 1'b1;
        state_d        = ST_FLUSH_OUT;
      end

      ST_FLUSH_OUT: begin
        flush_req   = 1'b1;
        flush_pc    = dpc_r;
        issue_stall = 1'b1;
        if (flush_ack) begin
          state_d       = ST_RUN;
          step_armed_d  = dbg_step_r;
          step_issued_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign drain_timeout = drain_timeout_q;

endmodule

// File: tb/tb_sirv_debug_entry_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for sirv_debug_entry_ctrl.  Directed scenarios with literal
// expectations, followed by a randomized run.  A behavioural model advances
// on every rising edge and a single compare process checks every output on
// every falling edge.  Expected dpc writes are also queued and matched
// against the DUT write strobe.
// ---------------------------------------------------------------------------
module tb_sirv_debug_entry_ctrl;

  localparam int          PC_SIZE  = 32;
  localparam int          DRAIN_TO = 8;
  localparam int          CNT_W    = 4;
  localparam logic [31:0] ROM_ADDR = 32'h0000_0800;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic               dbg_irq_r, dbg_halt_r, dbg_step_r, dbg_ebreakm_r;
  logic [PC_SIZE-1:0] dpc_r;
  logic               cmt_valid;
  logic [PC_SIZE-1:0] cmt_pc, cmt_npc;
  logic               cmt_ebreak, cmt_dret, pipe_idle;
  logic [PC_SIZE-1:0] next_pc;
  logic               flush_ack;
  logic [PC_SIZE-1:0] cmt_dpc;
  logic               cmt_dpc_ena;
  logic [2:0]         cmt_dcause;
  logic               cmt_dcause_ena, issue_stall, flush_req;
  logic [PC_SIZE-1:0] flush_pc;
  logic               core_halted, drain_timeout;

  sirv_debug_entry_ctrl #(
    .PC_SIZE      (PC_SIZE),
    .DBG_ROM_ADDR (ROM_ADDR),
    .DRAIN_TO     (DRAIN_TO),
    .CNT_W        (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .dbg_irq_r      (dbg_irq_r),
    .dbg_halt_r     (dbg_halt_r),
    .dbg_step_r     (dbg_step_r),
    .dbg_ebreakm_r  (dbg_ebreakm_r),
    .dpc_r          (dpc_r),
    .cmt_valid      (cmt_valid),
    .cmt_pc         (cmt_pc),
    .cmt_npc        (cmt_npc),
    .cmt_ebreak     (cmt_ebreak),
    .cmt_dret       (cmt_dret),
    .pipe_idle      (pipe_idle),
    .next_pc        (next_pc),
    .flush_ack      (flush_ack),
    .cmt_dpc        (cmt_dpc),
    .cmt_dpc_ena    (cmt_dpc_ena),
    .cmt_dcause     (cmt_dcause),
    .cmt_dcause_ena (cmt_dcause_ena),
    .issue_stall    (issue_stall),
    .flush_req      (flush_req),
    .flush_pc       (flush_pc),
    .core_halted    (core_halted),
    .drain_timeout  (drain_timeout)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;
  logic [PC_SIZE-1:0] exp_q[$];

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Tracks which phase of the debug life-cycle the core is in and what was
  // captured on entry; outputs are derived from the phase table below.
  typedef enum {P_RUN, P_DRAIN, P_ENTER, P_FLUSH_IN, P_HALTED, P_EXIT, P_FLUSH_OUT} phase_e;
  phase_e             m_phase        = P_RUN;
  int                 m_cause        = 0;
  logic [PC_SIZE-1:0] m_dpc          = '0;
  bit                 m_armed        = 1'b0;
  int                 m_run_cycles   = 0;  // cycles spent in RUN since return
  int                 m_drain_cycles = 0;  // drain cycles already elapsed
  bit                 m_timeout      = 1'b0;

  task automatic m_enter(input int cause, input logic [PC_SIZE-1:0] pc);
    m_phase = P_ENTER;
    m_cause = cause;
    m_dpc   = pc;
    exp_q.push_back(pc & 32'hFFFF_FFFE);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_phase = P_RUN; m_cause = 0; m_dpc = '0; m_armed = 1'b0;
      m_run_cycles = 0; m_drain_cycles = 0; m_timeout = 1'b0;
    end else begin
      case (m_phase)
        P_RUN: begin
          if (m_run_cycles < 1000) m_run_cycles++;
          if (cmt_valid && cmt_ebreak && dbg_ebreakm_r) m_enter(1, cmt_pc);
          else if (cmt_valid && m_armed && !cmt_dret) begin
            m_enter(4, cmt_npc);
            m_armed = 1'b0;
          end else if (dbg_irq_r || dbg_halt_r) begin
            m_phase = P_DRAIN;
            m_drain_cycles = 0;
          end
        end
        P_DRAIN: begin
          if (cmt_valid && cmt_ebreak && dbg_ebreakm_r) m_enter(1, cmt_pc);
          else if (pipe_idle) m_enter(3, next_pc);
          else if (m_drain_cycles + 1 == DRAIN_TO) begin
            m_enter(3, next_pc);
            m_timeout = 1'b1;
          end else m_drain_cycles++;
        end
        P_ENTER:    m_phase = P_FLUSH_IN;
        P_FLUSH_IN: if (flush_ack) m_phase = P_HALTED;
        P_HALTED:   if (cmt_valid && cmt_dret) m_phase = P_EXIT;
        P_EXIT:     m_phase = P_FLUSH_OUT;
        P_FLUSH_OUT: if (flush_ack) begin
          m_phase      = P_RUN;
          m_armed      = dbg_step_r;
          m_run_cycles = 0;
        end
        default: m_phase = P_RUN;
      endcase
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin : cmp
    logic [31:0] e_dpc, e_fpc;
    logic [2:0]  e_cause;
    logic        e_dpc_ena, e_cause_ena, e_stall, e_freq, e_halted;
    logic [31:0] q_exp;
    if (check_en) begin
      e_dpc = '0; e_fpc = '0; e_cause = '0;
      e_dpc_ena = 0; e_cause_ena = 0; e_stall = 0; e_freq = 0; e_halted = 0;
      case (m_phase)
        P_RUN:      e_stall = m_armed && (m_run_cycles > 0);
        P_DRAIN:    e_stall = 1;
        P_ENTER: begin
          e_dpc = m_dpc & 32'hFFFF_FFFE; e_dpc_ena = 1;
          e_cause = 3'(m_cause); e_cause_ena = 1; e_stall = 1;
        end
        P_FLUSH_IN:  begin e_freq = 1; e_fpc = ROM_ADDR; e_stall = 1; end
        P_HALTED:    e_halted = 1;
        P_EXIT:      begin e_cause_ena = 1; e_stall = 1; end
        P_FLUSH_OUT: begin e_freq = 1; e_fpc = dpc_r; e_stall = 1; end
        default: ;
      endcase
      chkw("cmt_dpc", cmt_dpc, e_dpc);
      chk1("cmt_dpc_ena", cmt_dpc_ena, e_dpc_ena);
      chkw("cmt_dcause", 32'(cmt_dcause), 32'(e_cause));
      chk1("cmt_dcause_ena", cmt_dcause_ena, e_cause_ena);
      chk1("issue_stall", issue_stall, e_stall);
      chk1("flush_req", flush_req, e_freq);
      chkw("flush_pc", flush_pc, e_fpc);
      chk1("core_halted", core_halted, e_halted);
      chk1("drain_timeout", drain_timeout, m_timeout);
      if (cmt_dpc_ena === 1'b1) begin
        if (exp_q.size() == 0) begin
          q_exp = '0;
          chk1("dpc_write_expected", 1'b1, 1'b0);
        end else begin
          q_exp = exp_q.pop_front();
          chkw("dpc_write_queue", cmt_dpc, q_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cmt();
    cmt_valid = 0; cmt_ebreak = 0; cmt_dret = 0;
  endtask

  task automatic drive_idle();
    dbg_irq_r = 0; dbg_halt_r = 0; dbg_step_r = 0; dbg_ebreakm_r = 0;
    dpc_r = '0; cmt_pc = '0; cmt_npc = '0; pipe_idle = 0; next_pc = '0;
    flush_ack = 0;
    clr_cmt();
  endtask

  task automatic drive_random();
    rst           = ($urandom_range(0, 249) == 0);
    dbg_irq_r     = ($urandom_range(0, 24) == 0);
    dbg_halt_r    = ($urandom_range(0, 39) == 0);
    dbg_step_r    = ($urandom_range(0, 2) == 0);
    dbg_ebreakm_r = ($urandom_range(0, 3) != 0);
    dpc_r         = $urandom;
    cmt_valid     = ($urandom_range(0, 1) == 1);
    cmt_pc        = $urandom;
    cmt_npc       = $urandom;
    cmt_ebreak    = ($urandom_range(0, 9) == 0);
    cmt_dret      = ($urandom_range(0, 3) == 0);
    pipe_idle     = ($urandom_range(0, 5) == 0);
    next_pc       = $urandom;
    flush_ack     = ($urandom_range(0, 2) == 0);
  endtask

  // Leave HALTED through dret and a flush acked in its first cycle.
  task automatic do_exit(input logic step);
    dbg_step_r = step;
    cmt_valid = 1; cmt_dret = 1;
    tick();            // EXIT
    clr_cmt();
    tick();            // FLUSH_OUT
    flush_ack = 1;
    tick();            // RUN
    flush_ack = 0;
    dbg_step_r = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive_idle();
    rst = 1;
    tick(); tick();
    check_en = 1;
    rst = 0;

    // reset state
    chk1("rst_flush_req", flush_req, 1'b0);
    chk1("rst_core_halted", core_halted, 1'b0);
    chk1("rst_issue_stall", issue_stall, 1'b0);
    chk1("rst_drain_timeout", drain_timeout, 1'b0);

    // ebreak entry
    dbg_ebreakm_r = 1; cmt_valid = 1; cmt_ebreak = 1; cmt_pc = 32'h100;
    tick();
    chk1("ebr_dpc_ena", cmt_dpc_ena, 1'b1);
    chkw("ebr_dpc", cmt_dpc, 32'h100);
    chkw("ebr_dcause", 32'(cmt_dcause), 32'd1);
    chk1("ebr_dcause_ena", cmt_dcause_ena, 1'b1);
    clr_cmt();
    tick();
    chk1("ebr_flush_req", flush_req, 1'b1);
    chkw("ebr_flush_pc", flush_pc, 32'h800);
    tick();
    chk1("ebr_flush_hold", flush_req, 1'b1);
    flush_ack = 1;
    tick();
    flush_ack = 0;
    chk1("ebr_halted", core_halted, 1'b1);
    chk1("ebr_flush_drop", flush_req, 1'b0);
    chk1("ebr_rom_runs", issue_stall, 1'b0);

    // dret exit, ack after four flush cycles
    dpc_r = 32'h204;
    cmt_valid = 1; cmt_dret = 1;
    tick();
    chk1("exit_dcause_ena", cmt_dcause_ena, 1'b1);
    chkw("exit_dcause", 32'(cmt_dcause), 32'd0);
    chk1("exit_dpc_ena", cmt_dpc_ena, 1'b0);
    chk1("exit_not_halted", core_halted, 1'b0);
    clr_cmt();
    tick();
    chkw("exit_flush_pc", flush_pc, 32'h204);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("exit_flush_hold", flush_req, 1'b1);
    end
    flush_ack = 1;
    tick();
    flush_ack = 0;
    chk1("exit_flush_drop", flush_req, 1'b0);
    chk1("exit_run", core_halted, 1'b0);

    // halt request drain, request dropped mid-drain
    dbg_irq_r = 1; next_pc = 32'h204;
    for (int i = 0; i < 3; i++) begin
      tick();
      dbg_irq_r = 0;
      chk1("drain_stall", issue_stall, 1'b1);
    end
    pipe_idle = 1;
    tick();
    pipe_idle = 0;
    chkw("drain_dcause", 32'(cmt_dcause), 32'd3);
    chkw("drain_dpc", cmt_dpc, 32'h204);
    chk1("drain_no_timeout", drain_timeout, 1'b0);
    tick();
    flush_ack = 1;     // ack in the first FLUSH_IN cycle
    tick();
    flush_ack = 0;
    chk1("drain_halted", core_halted, 1'b1);

    // single step
    do_exit(1'b1);
    chk1("step_first_issue", issue_stall, 1'b0);
    tick();
    chk1("step_stall", issue_stall, 1'b1);
    cmt_valid = 1; cmt_pc = 32'h204; cmt_npc = 32'h208;
    tick();
    clr_cmt();
    chkw("step_dcause", 32'(cmt_dcause), 32'd4);
    chkw("step_dpc", cmt_dpc, 32'h208);
    flush_ack = 1;
    tick(); tick();
    flush_ack = 0;
    chk1("step_halted", core_halted, 1'b1);
    do_exit(1'b0);
    tick();
    chk1("nostep_no_stall", issue_stall, 1'b0);

    // drain timeout
    dbg_irq_r = 1; next_pc = 32'h40C;
    tick();
    dbg_irq_r = 0;
    for (int i = 0; i < DRAIN_TO - 1; i++) begin
      tick();
      chk1("to_still_drain", cmt_dcause_ena, 1'b0);
    end
    tick();
    chk1("to_flag", drain_timeout, 1'b1);
    chkw("to_dcause", 32'(cmt_dcause), 32'd3);
    chkw("to_dpc", cmt_dpc, 32'h40C);
    flush_ack = 1;
    tick(); tick();
    flush_ack = 0;
    do_exit(1'b0);
    chk1("to_sticky", drain_timeout, 1'b1);

    // ebreak beats halt request, then reset mid-flush
    dbg_ebreakm_r = 1; cmt_valid = 1; cmt_ebreak = 1; cmt_pc = 32'h301; dbg_irq_r = 1;
    tick();
    clr_cmt(); dbg_irq_r = 0;
    chkw("prio_dcause", 32'(cmt_dcause), 32'd1);
    chkw("prio_dpc_aligned", cmt_dpc, 32'h300);
    tick();
    chk1("prio_flush_req", flush_req, 1'b1);
    rst = 1;
    tick();
    rst = 0;
    chk1("rstf_flush_req", flush_req, 1'b0);
    chkw("rstf_flush_pc", flush_pc, 32'h0);
    chk1("rstf_stall", issue_stall, 1'b0);
    chk1("rstf_timeout", drain_timeout, 1'b0);
    chk1("rstf_dcause_ena", cmt_dcause_ena, 1'b0);

    // randomized run
    for (int i = 0; i < 4000; i++) begin
      drive_random();
      tick();
    end
    drive_idle();
    rst = 0;
    @(negedge clk);
    #1;
    chkw("dpc_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sirv_debug_entry_ctrl.md
Name: sirv_debug_entry_ctrl

Overview:
- Sequences the core into and out of debug mode, and drives the commit-side write ports of the debug CSR block (dpc, dcause).
- Arbitrates the entry sources: ebreak, halt request and single-step.
- Drains the pipeline and redirects fetch to the debug ROM; on dret it redirects fetch back to dpc.
- Sits between the commit stage, the debug CSR block and the IFU flush interface.

Parameters:
- PC_SIZE, 32, PC width.
- DBG_ROM_ADDR, 32'h0000_0800, fetch target on debug entry.
- DRAIN_TO, 64, maximum cycles to wait for pipe_idle before forced entry.
- CNT_W, 7, width of the drain counter; must satisfy 2^CNT_W > DRAIN_TO.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- dbg_irq_r  in  1  external debug halt request (level)
- dbg_halt_r  in  1  dcsr.halt
- dbg_step_r  in  1  dcsr.step
- dbg_ebreakm_r  in  1  dcsr.ebreakm
- dpc_r  in  PC_SIZE  current dpc, used as the return address
- cmt_valid  in  1  instruction retires this cycle
- cmt_pc  in  PC_SIZE  PC of the retiring instruction
- cmt_npc  in  PC_SIZE  next PC after the retiring instruction
- cmt_ebreak  in  1  retiring instruction is ebreak (qualified by cmt_valid)
- cmt_dret  in  1  retiring instruction is dret (qualified by cmt_valid)
- pipe_idle  in  1  no instruction in flight
- next_pc  in  PC_SIZE  PC of the next unissued instruction
- flush_ack  in  1  IFU accepted the flush
- cmt_dpc  out  PC_SIZE  dpc write data
- cmt_dpc_ena  out  1  dpc write strobe
- cmt_dcause  out  3  dcause write data
- cmt_dcause_ena  out  1  dcause write strobe
- issue_stall  out  1  block instruction issue
- flush_req  out  1  fetch redirect request
- flush_pc  out  PC_SIZE  redirect target
- core_halted  out  1  core is in debug mode, parked in the ROM
- drain_timeout  out  1  sticky: a drain expired without pipe_idle

Behaviour:
- Cause codes: 1 = ebreak, 3 = haltreq, 4 = step, 0 = exit. dcause 0 means not in debug mode.
- States: RUN, DRAIN, ENTER, FLUSH_IN, HALTED, EXIT, FLUSH_OUT.
- Internal registers: cause_q[2:0], dpc_q[PC_SIZE-1:0], step_armed, drain_cnt[CNT_W-1:0], drain_timeout.
- Reset (rst=1 at a clk edge, in any state, including mid-flush):
  - state = RUN; every output 0; cause_q = 0; dpc_q = 0; step_armed = 0; drain_cnt = 0; drain_timeout = 0.
- RUN, evaluated each cycle in priority order:
  - cmt_valid & cmt_ebreak & dbg_ebreakm_r -> ENTER; cause_q = 1; dpc_q = cmt_pc.
  - Else cmt_valid & step_armed & ~cmt_dret -> ENTER; cause_q = 4; dpc_q = cmt_npc; step_armed cleared.
  - Else dbg_irq_r | dbg_halt_r -> DRAIN; drain_cnt = 0.
  - ebreak with ebreakm = 0 is ignored; the normal exception path handles it.
  - cmt_dret in RUN is ignored.
- Step issue rule: after the first issue following exit, issue_stall = 1 while step_armed, so exactly one instruction retires before re-entry.
- DRAIN:
  - issue_stall = 1; drain_cnt increments every cycle.
  - pipe_idle -> ENTER; cause_q = 3; dpc_q = next_pc.
  - drain_cnt == DRAIN_TO-1 without pipe_idle -> ENTER with the same capture, and drain_timeout set to 1.
  - A retire during DRAIN with ebreak & ebreakm -> ENTER with cause 1 instead.
  - If the request deasserts during DRAIN, the drain still completes and entry still happens.
- ENTER (exactly 1 cycle):
  - cmt_dpc_ena = 1, cmt_dpc = {dpc_q[PC_SIZE-1:1], 1'b0}.
  - cmt_dcause_ena = 1, cmt_dcause = cause_q.
  - issue_stall = 1. Next state FLUSH_IN.
- FLUSH_IN:
  - flush_req = 1, flush_pc = DBG_ROM_ADDR, held stable until flush_ack.
  - Exits at the cycle flush_ack = 1; flush_req drops the next cycle.
  - Next state HALTED. An ack may arrive in the first FLUSH_IN cycle.
- HALTED:
  - core_halted = 1; issue_stall = 0, so ROM code executes.
  - New halt, step or ebreak sources are ignored.
  - cmt_valid & cmt_dret -> EXIT.
- EXIT (1 cycle):
  - cmt_dcause_ena = 1, cmt_dcause = 0; cmt_dpc_ena = 0.
  - core_halted = 0; issue_stall = 1. Next state FLUSH_OUT.
- FLUSH_OUT:
  - flush_req = 1, flush_pc = dpc_r, held until flush_ack, then RUN.
  - step_armed = dbg_step_r, sampled at the flush_ack cycle.
  - If dbg_halt_r is still 1 on return, RUN re-enters DRAIN on the next cycle.
- Output timing: all outputs are decoded from registered state and registers only; none depend combinationally on inputs except flush_pc = dpc_r in FLUSH_OUT.
- drain_timeout is cleared only by rst.

Test Plan:
- ebreak entry: RUN, ebreakm=1, retire ebreak at cmt_pc=0x100 -> next cycle cmt_dpc_ena=1, cmt_dpc=0x100, cmt_dcause=1; then flush_req with flush_pc=0x800; ack after 2 cycles -> core_halted=1.
- haltreq drain: dbg_irq_r=1, pipe_idle rises 3 cycles later with next_pc=0x204 -> issue_stall for 3 cycles; ENTER with dcause=3, dpc=0x204; drain_timeout=0.
- dret exit: in HALTED with dpc_r=0x204, retire dret -> 1-cycle dcause write 0; flush_req with flush_pc=0x204 held 4 cycles until ack -> RUN, core_halted=0.
- single-step: exit with dbg_step_r=1, retire one instruction with cmt_npc=0x208 -> ENTER with dcause=4, dpc=0x208; issue_stall=1 after the first issue.
- drain timeout: DRAIN_TO=8, haltreq, pipe_idle held 0 -> forced ENTER after 8 drain cycles, drain_timeout=1, which stays 1 after exit.
- priority and reset: ebreak retire (ebreakm=1) in the same cycle as dbg_irq_r=1 -> dcause=1, not 3. Asserting rst in FLUSH_IN -> state RUN, flush_req=0 and all outputs 0 the next cycle.
